fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single write port of the 32-entry, 8-bit FIFO between two producers, A and B.
- Each producer gets a valid/ready style grant. A granted producer keeps the port for a burst of up to BURST_LEN words.
- Writes stop before the FIFO overflows, using F_FULL_N and the USE_DW fill level.
- Sits directly in front of the FIFO: drives its WRITE and DATA_IN. Does not touch READ.

Parameters:
- BURST_LEN, 4: maximum words one producer may write per grant (1..15).
- HIGH_WATER, 30: USE_DW value at or above which no new burst is granted (1..31).
- WIDTH, 8: data width; must equal the FIFO data width.

Ports:
- CLOCK  input  1  system clock, rising edge
- RESET_N  input  1  asynchronous active-low reset
- CLEAR_N  input  1  synchronous active-low clear; same effect as reset, applied on the clock edge
- REQ_A  input  1  producer A has a word on DATA_A
- DATA_A  input  WIDTH  producer A data
- GNT_A  output  1  A owns the port; a word is accepted in any cycle where REQ_A & GNT_A & WRITE
- REQ_B  input  1  producer B request
- DATA_B  input  WIDTH  producer B data
- GNT_B  output  1  B owns the port
- F_FULL_N  input  1  FIFO full flag, active low
- USE_DW  input  5  FIFO fill level
- WRITE  output  1  FIFO write strobe
- FIFO_DATA  output  WIDTH  to FIFO DATA_IN
- CNT_A  output  16  words accepted from A (see optional feature)
- CNT_B  output  16  words accepted from B (see optional feature)

Behaviour:
- Reset/clear (RESET_N=0 async, or CLEAR_N=0 at a clock edge) sets:
  - state IDLE, GNT_A=GNT_B=0, burst counter 0, last-served pointer = B (so A wins first), CNT_A=CNT_B=0.
  - WRITE=0 and FIFO_DATA=0 during reset.
- States: IDLE, OWN_A, OWN_B. GNT_A=1 only in OWN_A; GNT_B=1 only in OWN_B. Grants are registered.
- IDLE:
  - If USE_DW>=HIGH_WATER or F_FULL_N=0: stay in IDLE.
  - Otherwise, if only one REQ is high: go to that producer's OWN state.
  - If both REQs are high: go to the producer not served last.
  - Burst counter loads 0 on entry. The grant appears one cycle after REQ is sampled (1-cycle grant latency).
- WRITE = (GNT_A&REQ_A | GNT_B&REQ_B) & F_FULL_N. Combinational, same cycle.
- FIFO_DATA = DATA_A in OWN_A, DATA_B in OWN_B, 0 in IDLE.
- Each accepted word increments the burst counter.
- OWN_x exits to IDLE and records x as last served when any of these holds:
  - the burst counter reaches BURST_LEN on an accepted word;
  - REQ_x is low at a clock edge;
  - F_FULL_N is low at a clock edge.
- No direct OWN_A to OWN_B hop: a 1-cycle IDLE bubble always separates grants.
- Producer B may hold a grant at most BURST_LEN+1 cycles while A waits, and vice versa. No starvation.
- Full boundary: with F_FULL_N=0, WRITE is forced to 0 in that same cycle, even while granted. No word is lost or duplicated; the producer holds its data until accepted.
- High water is checked only when granting. A burst in progress may fill the FIFO to full; F_FULL_N then stops it.
- Reset asserted mid-burst: grant drops immediately; the partially written burst stays in the FIFO.

Optional Feature:
- Macro: FIFO_ARB_STATS_EN.
- Defined:
  - CNT_A/CNT_B increment on each word accepted from A/B.
  - They saturate at 16'hFFFF.
  - They clear on reset and clear.
- Not defined: CNT_A and CNT_B are tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset, then REQ_A=1 with DATA_A=8'h11..8'h14 and REQ_B=0 → GNT_A rises 1 cycle later; 4 writes; GNT_A falls; 1 IDLE cycle; A re-granted.
- REQ_A=REQ_B=1 held for 20 cycles → grants alternate A,B,A,B. Each grant gives 4 writes. Total 16 words in 20 cycles. CNT_A=CNT_B=8 with FIFO_ARB_STATS_EN.
- USE_DW=30, REQ_B=1 → GNT_B stays 0. Drive USE_DW=29 → GNT_B=1 on the next cycle.
- Granted A, F_FULL_N driven low on the 2nd word → WRITE=0 in that cycle, GNT_A drops next edge. FIFO contents are 1 word; no overrun.
- REQ_B dropped after 2 words of a 4-word burst → B released; a pending A is granted after 1 IDLE cycle.
- RESET_N pulsed low mid-burst asynchronously → GNT_A/GNT_B/WRITE go 0 immediately, with no clock edge. After release, A wins the next simultaneous request.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter that shares the single write
// port of a FIFO between two producers, A and B, in bursts of BURST_LEN words.
// A new burst is granted only below the HIGH_WATER fill level. F_FULL_N gates
// every write and ends a burst that is in progress.
// Optional per-producer word counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int BURST_LEN  = 4,
  parameter int HIGH_WATER = 30,
  parameter int WIDTH      = 8
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             CLEAR_N,
  input  logic             REQ_A,
  input  logic [WIDTH-1:0] DATA_A,
  output logic             GNT_A,
  input  logic             REQ_B,
  input  logic [WIDTH-1:0] DATA_B,
  output logic             GNT_B,
  input  logic             F_FULL_N,
  input  logic [4:0]       USE_DW,
  output logic             WRITE,
  output logic [WIDTH-1:0] FIFO_DATA,
  output logic [15:0]      CNT_A,
  output logic [15:0]      CNT_B
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);
  localparam logic [4:0] HIGH_MARK  = 5'(HIGH_WATER);

  state_t     state;
  state_t     next_state;
  logic [3:0] burst_cnt;
  logic       last_b;
  logic       grant_ok;
  logic       burst_done;

  // A new burst may start only below the high-water mark and while not full.
  assign grant_ok   = (USE_DW < HIGH_MARK) && F_FULL_N;
  assign burst_done = WRITE && (burst_cnt == BURST_LAST);

  // State register, burst counter and last-served pointer; reset favours A.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
      last_b    <= 1'b1;
    end else if (!CLEAR_N) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
      last_b    <= 1'b1;
    end else begin
      state <= next_state;
      if (state == IDLE) begin
        burst_cnt <= 4'd0;
      end else if (WRITE) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
      if (state == OWN_A && next_state == IDLE) begin
        last_b <= 1'b0;
      end else if (state == OWN_B && next_state == IDLE) begin
        last_b <= 1'b1;
      end
    end
  end

  // Next-state logic: every grant returns through IDLE, which gives the bubble.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_ok) begin
          if (REQ_A && REQ_B) begin
            next_state = last_b ? OWN_A : OWN_B;
          end else if (REQ_A) begin
            next_state = OWN_A;
          end else if (REQ_B) begin
            next_state = OWN_B;
          end
        end
      end
      OWN_A: begin
        if (burst_done || !REQ_A || !F_FULL_N) begin
          next_state = IDLE;
        end
      end
      OWN_B: begin
        if (burst_done || !REQ_B || !F_FULL_N) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs: grants decode the state flops; the write strobe is gated by full.
  always_comb begin
    GNT_A     = (state == OWN_A);
    GNT_B     = (state == OWN_B);
    WRITE     = (((state == OWN_A) && REQ_A) || ((state == OWN_B) && REQ_B)) && F_FULL_N;
    FIFO_DATA = '0;
    if (state == OWN_A) begin
      FIFO_DATA = DATA_A;
    end else if (state == OWN_B) begin
      FIFO_DATA = DATA_B;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;

  // Saturating counts of words accepted from each producer.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_a <= 16'd0;
      cnt_b <= 16'd0;
    end else if (!CLEAR_N) begin
      cnt_a <= 16'd0;
      cnt_b <= 16'd0;
    end else begin
      if (WRITE && state == OWN_A && cnt_a != 16'hFFFF) begin
        cnt_a <= cnt_a + 16'd1;
      end
      if (WRITE && state == OWN_B && cnt_b != 16'hFFFF) begin
        cnt_b <= cnt_b + 16'd1;
      end
    end
  end

  assign CNT_A = cnt_a;
  assign CNT_B = cnt_b;
`else
  assign CNT_A = 16'd0;
  assign CNT_B = 16'd0;
`endif

endmodule
